drp_access_ctrl: RTL and testbench

DRP_ACCESS_CTRL -- requirements
Module: drp_access_ctrl

---
 rtl/drp_access_ctrl.sv | 162 ++++++++++++++++
 tb/tb_drp_access_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/drp_access_ctrl.sv
// DRP access controller: turns single read/write/RMW requests into DRP
// bus transactions with a per-access timeout, status and error count.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   req_valid/req_ready            request handshake (ready only in IDLE)
//   req_op/addr/wdata/mask         00 rd, 01 wr, 10 rmw, 11 reserved
//   rsp_valid/rdata/status         one-cycle response, held data/status
//   busy, err_count                activity flag, saturating error count
//   drp_en/we/addr/di              DRP master outputs
//   drp_do, drp_rdy                DRP slave returns
module drp_access_ctrl #(
    parameter int ADDR_W         = 10,
    parameter int DATA_W         = 16,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int TO_W           = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [DATA_W-1:0] req_mask,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [1:0]        rsp_status,
    output logic              busy,
    output logic [7:0]        err_count,
    output logic              drp_en,
    output logic              drp_we,
    output logic [ADDR_W-1:0] drp_addr,
    output logic [DATA_W-1:0] drp_di,
    input  logic [DATA_W-1:0] drp_do,
    input  logic              drp_rdy
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_RD_ISSUE = 3'd1;
    localparam logic [2:0] S_RD_WAIT  = 3'd2;
    localparam logic [2:0] S_WR_ISSUE = 3'd3;
    localparam logic [2:0] S_WR_WAIT  = 3'd4;
    localparam logic [2:0] S_RESP     = 3'd5;

    localparam logic [1:0] OP_RD  = 2'b00;
    localparam logic [1:0] OP_WR  = 2'b01;
    localparam logic [1:0] OP_RMW = 2'b10;

    localparam logic [1:0] ST_OK  = 2'b00;
    localparam logic [1:0] ST_TO  = 2'b01;
    localparam logic [1:0] ST_BAD = 2'b10;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);

    logic [2:0]        state;
    logic [1:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wval_q;
    logic [DATA_W-1:0] mask_q;
    logic [DATA_W-1:0] rd_q;
    logic [TO_W-1:0]   to_cnt;
    logic              to_hit;

    assign to_hit = (to_cnt == TO_LAST);

    // Ready is withheld while reset is asserted, even though the
    // state register already sits in IDLE after the first reset edge.
    assign req_ready = (state == S_IDLE) && !rst;
    assign busy      = (state != S_IDLE);
    assign rsp_valid = (state == S_RESP);
    assign drp_en    = (state == S_RD_ISSUE) || (state == S_WR_ISSUE);
    assign drp_we    = (state == S_WR_ISSUE);
    assign drp_addr  = addr_q;
    assign drp_di    = wval_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            op_q       <= '0;
            addr_q     <= '0;
            wval_q     <= '0;
            mask_q     <= '0;
            rd_q       <= '0;
            to_cnt     <= '0;
            rsp_rdata  <= '0;
            rsp_status <= '0;
            err_count  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        op_q   <= req_op;
                        addr_q <= req_addr;
                        wval_q <= req_wdata;
                        mask_q <= req_mask;
                        rd_q   <= '0;
                        case (req_op)
                            OP_RD, OP_RMW: state <= S_RD_ISSUE;
                            OP_WR:         state <= S_WR_ISSUE;
                            default: begin
                                state      <= S_RESP;
                                rsp_rdata  <= '0;
                                rsp_status <= ST_BAD;
                            end
                        endcase
                    end
                end
                S_RD_ISSUE: begin
                    to_cnt <= '0;
                    state  <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    // A reply on the last wait cycle still wins over abort.
                    if (drp_rdy) begin
                        rd_q <= drp_do;
                        if (op_q == OP_RMW) begin
                            wval_q <= (drp_do & ~mask_q) | (wval_q & mask_q);
                            state  <= S_WR_ISSUE;
                        end else begin
                            rsp_rdata  <= drp_do;
                            rsp_status <= ST_OK;
                            state      <= S_RESP;
                        end
                    end else if (to_hit) begin
                        rsp_rdata  <= '0;
                        rsp_status <= ST_TO;
                        state      <= S_RESP;
                    end else begin
                        to_cnt <= to_cnt + TO_ONE;
                    end
                end
                S_WR_ISSUE: begin
                    to_cnt <= '0;
                    state  <= S_WR_WAIT;
                end
                S_WR_WAIT: begin
                    if (drp_rdy) begin
                        rsp_rdata  <= (op_q == OP_RMW) ? rd_q : '0;
                        rsp_status <= ST_OK;
                        state      <= S_RESP;
                    end else if (to_hit) begin
                        rsp_rdata  <= '0;
                        rsp_status <= ST_TO;
                        state      <= S_RESP;
                    end else begin
                        to_cnt <= to_cnt + TO_ONE;
                    end
                end
                S_RESP: begin
                    if ((rsp_status != ST_OK) && (err_count != 8'hFF)) begin
                        err_count <= err_count + 8'd1;
                    end
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_drp_access_ctrl.sv
// Scoreboard bench for drp_access_ctrl: a reference model queues expected
// DRP accesses and responses; slave and monitor processes check them.
module tb_drp_access_ctrl;

    localparam int AW = 10;
    localparam int DW = 16;
    localparam int TO = 1000;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [1:0]    req_op;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [DW-1:0] req_mask;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_status;
    logic          busy;
    logic [7:0]    err_count;
    logic          drp_en;
    logic          drp_we;
    logic [AW-1:0] drp_addr;
    logic [DW-1:0] drp_di;
    logic [DW-1:0] drp_do;
    logic          drp_rdy;

    drp_access_ctrl #(
        .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO), .TO_W(11)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_mask(req_mask),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_status(rsp_status), .busy(busy), .err_count(err_count),
        .drp_en(drp_en), .drp_we(drp_we), .drp_addr(drp_addr),
        .drp_di(drp_di), .drp_do(drp_do), .drp_rdy(drp_rdy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] rdata;
        logic [1:0]    status;
        int            cyc;
    } rsp_t;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] di;
        int            delay;
        logic [DW-1:0] rdata;
    } drp_t;

    rsp_t          rsp_q[$];
    drp_t          drp_q[$];
    logic [DW-1:0] ref_mem [1024];
    int            err_model = 0;
    int            exp_rsp   = 0;
    int            rsp_seen  = 0;
    logic [DW-1:0] last_rdata  = '0;
    logic [1:0]    last_status = '0;

    int total  = 0;
    int passed = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic bit ok(input int d);
        return (d >= 1) && (d <= TO);
    endfunction

    // Cycles from drp_en to the last wait cycle (reply or abort).
    function automatic int eff(input int d);
        return ok(d) ? d : TO;
    endfunction

    function automatic int rand_k();
        int r;
        r = $urandom_range(0, 49);
        if (r == 0) return TO;
        if (r == 1) return 0;
        return $urandom_range(1, 6);
    endfunction

    // DRP slave: checks each access against the model, replies after delay.
    initial begin : slave
        int            cnt;
        logic [DW-1:0] reply;
        drp_t          cur;
        cnt     = 0;
        reply   = '0;
        drp_rdy = 1'b0;
        drp_do  = '0;
        forever begin
            @(negedge clk);
            drp_rdy = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    drp_rdy = 1'b1;
                    drp_do  = reply;
                end
            end
            if (drp_en === 1'b1) begin
                if (drp_q.size() == 0) begin
                    chk("drp_en_unexpected", drp_en, 0);
                end else begin
                    cur = drp_q.pop_front();
                    chk("drp_we", drp_we, cur.we);
                    chk("drp_addr", drp_addr, cur.addr);
                    if (cur.we) chk("drp_di", drp_di, cur.di);
                    cnt   = cur.delay;
                    reply = cur.rdata;
                end
            end
        end
    end

    // Response monitor.
    initial begin : monitor
        rsp_t e;
        forever begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                if (rsp_q.size() == 0) begin
                    chk("rsp_unexpected", rsp_valid, 0);
                end else begin
                    e = rsp_q.pop_front();
                    chk("rsp_rdata", rsp_rdata, e.rdata);
                    chk("rsp_status", rsp_status, e.status);
                    chk("rsp_cycle", cyc, e.cyc);
                    rsp_seen++;
                end
            end
        end
    end

    task automatic push_rsp(input logic [DW-1:0] rd, input logic [1:0] st, input int c);
        rsp_t r;
        drp_t unused;
        unused.we = 1'b0;
        r.rdata  = rd;
        r.status = st;
        r.cyc    = c;
        rsp_q.push_back(r);
        exp_rsp++;
        last_rdata  = rd;
        last_status = st;
        if (st != 2'b00 && err_model < 255) err_model++;
    endtask

    task automatic push_drp(input logic we, input logic [AW-1:0] a,
                            input logic [DW-1:0] di, input int d,
                            input logic [DW-1:0] rd);
        drp_t x;
        x.we    = we;
        x.addr  = a;
        x.di    = di;
        x.delay = d;
        x.rdata = rd;
        drp_q.push_back(x);
    endtask

    task automatic do_txn(input logic [1:0] op, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd, input logic [DW-1:0] m,
                          input int k1, input int k2);
        int            t;
        int            e1;
        int            we;
        logic [DW-1:0] old;
        logic [DW-1:0] nw;
        @(negedge clk);
        chk("req_ready_idle", req_ready, 1);
        t  = cyc;
        e1 = t + 1;
        case (op)
            2'b00: begin
                push_drp(1'b0, a, '0, k1, ref_mem[a]);
                push_rsp(ok(k1) ? ref_mem[a] : '0, ok(k1) ? 2'b00 : 2'b01,
                         e1 + eff(k1) + 1);
            end
            2'b01: begin
                push_drp(1'b1, a, wd, k1, '0);
                ref_mem[a] = wd;
                push_rsp('0, ok(k1) ? 2'b00 : 2'b01, e1 + eff(k1) + 1);
            end
            2'b10: begin
                old = ref_mem[a];
                push_drp(1'b0, a, '0, k1, old);
                if (!ok(k1)) begin
                    push_rsp('0, 2'b01, e1 + eff(k1) + 1);
                end else begin
                    nw = (old & ~m) | (wd & m);
                    push_drp(1'b1, a, nw, k2, '0);
                    ref_mem[a] = nw;
                    we = e1 + k1 + 1;
                    push_rsp(ok(k2) ? old : '0, ok(k2) ? 2'b00 : 2'b01,
                             we + eff(k2) + 1);
                end
            end
            default: push_rsp('0, 2'b10, t + 1);
        endcase
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = a;
        req_wdata = wd;
        req_mask  = m;
        @(negedge clk);
        req_valid = 1'b0;
        req_op    = 2'($urandom);
        req_addr  = AW'($urandom);
        req_wdata = DW'($urandom);
        req_mask  = DW'($urandom);
        for (int i = 0; i < 2200 && rsp_seen < exp_rsp; i++) @(negedge clk);
        if (rsp_seen < exp_rsp) chk("rsp_wait_expired", rsp_seen, exp_rsp);
        if (k1 > TO || k2 > TO) repeat (10) @(negedge clk);
        @(negedge clk);
        chk("busy_idle", busy, 0);
        chk("err_count", err_count, err_model);
        chk("rsp_rdata_hold", rsp_rdata, last_rdata);
        chk("rsp_status_hold", rsp_status, last_status);
    endtask

    task automatic reset_mid_read(input logic [AW-1:0] a);
        @(negedge clk);
        push_drp(1'b0, a, '0, 10, ref_mem[a]);
        req_valid = 1'b1;
        req_op    = 2'b00;
        req_addr  = a;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("busy_in_wait", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_drp_en", drp_en, 0);
        chk("rst_ready_low", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        rst = 1'b0;
        err_model   = 0;
        last_rdata  = '0;
        last_status = '0;
        @(negedge clk);
        chk("post_rst_ready", req_ready, 1);
        chk("post_rst_err", err_count, 0);
        repeat (15) @(negedge clk);
        chk("late_rdy_busy", busy, 0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin : driver
        logic [AW-1:0] a;
        for (int i = 0; i < 1024; i++) ref_mem[i] = DW'($urandom);
        rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = '0;
        req_addr  = '0;
        req_wdata = '0;
        req_mask  = '0;
        repeat (3) @(negedge clk);
        chk("reset_ready", req_ready, 0);
        chk("reset_busy", busy, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_drp_en", drp_en, 0);
        chk("reset_err", err_count, 0);
        chk("reset_rdata", rsp_rdata, 0);
        chk("reset_status", rsp_status, 0);
        chk("reset_drp_addr", drp_addr, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", req_ready, 1);

        ref_mem[10'h05A] = 16'hBEEF;
        do_txn(2'b00, 10'h05A, 16'h0, 16'h0, 3, 1);
        do_txn(2'b01, 10'h3FF, 16'h1234, 16'h0, 1, 1);
        ref_mem[10'h100] = 16'hFF00;
        do_txn(2'b10, 10'h100, 16'h00AA, 16'h00FF, 2, 2);
        chk("rmw_mem", ref_mem[10'h100], 16'hFFAA);
        do_txn(2'b00, 10'h011, 16'h0, 16'h0, TO + 6, 1);
        do_txn(2'b00, 10'h022, 16'h0, 16'h0, TO, 1);
        do_txn(2'b01, 10'h033, 16'h5A5A, 16'h0, 0, 1);
        do_txn(2'b10, 10'h044, 16'h1111, 16'hF0F0, 0, 1);
        do_txn(2'b10, 10'h055, 16'h2222, 16'h0FF0, TO, TO);
        do_txn(2'b11, 10'h066, 16'h3333, 16'h0, 1, 1);
        reset_mid_read(10'h077);
        do_txn(2'b00, 10'h077, 16'h0, 16'h0, 2, 1);

        for (int n = 0; n < 120; n++) begin
            a = AW'($urandom);
            do_txn(2'($urandom_range(0, 3)), a, DW'($urandom), DW'($urandom),
                   rand_k(), rand_k());
        end

        for (int n = 0; n < 256; n++) begin
            do_txn(2'b11, AW'($urandom), DW'($urandom), DW'($urandom), 1, 1);
        end
        chk("err_saturated", err_count, 255);

        repeat (5) @(negedge clk);
        chk("rsp_q_left", rsp_q.size(), 0);
        chk("drp_q_left", drp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
